// File: rtl/time_set_ctrl.sv
// Button-driven time/alarm setting controller: debounces mode/inc buttons, runs the
// IDLE -> HOUR -> MIN setting FSM, and either rewrites the alarm or strobes a new clock time.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       SW_alarm,
  input  logic [3:0] clk_u_min_in,
  input  logic [2:0] clk_z_min_in,
  input  logic [3:0] clk_u_hour_in,
  input  logic [1:0] clk_z_hour_in,
  output logic [3:0] set_u_min,
  output logic [2:0] set_z_min,
  output logic [3:0] set_u_hour,
  output logic [1:0] set_z_hour,
  output logic       clk_load,
  output logic [3:0] alarm_u_min,
  output logic [2:0] alarm_z_min,
  output logic [3:0] alarm_u_hour,
  output logic [1:0] alarm_z_hour,
  output logic [1:0] set_state,
  output logic       target_alarm
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOUR = 2'd1;
  localparam logic [1:0] MIN  = 2'd2;

  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_inc, btn_mode};

  // Per button: 2-FF synchronizer, hold-time debounce, one-cycle pulse on accepted press.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic          sync1_reg, sync2_reg, deb_reg, deb_prev_reg, press_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          deb_reg      <= 1'b0;
          deb_prev_reg <= 1'b0;
          press_reg    <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          sync1_reg    <= btn_raw[gi];
          sync2_reg    <= sync1_reg;
          deb_prev_reg <= deb_reg;
          press_reg    <= deb_reg & ~deb_prev_reg;
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            deb_reg <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic       mode_p, inc_p;
  logic [1:0] state_reg;
  logic [3:0] wu_min, wu_hour;
  logic [2:0] wz_min;
  logic [1:0] wz_hour;

  assign mode_p = press[0];
  assign inc_p  = press[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      target_alarm <= 1'b0;
      clk_load     <= 1'b0;
      wu_min       <= 4'd0;
      wz_min       <= 3'd0;
      wu_hour      <= 4'd0;
      wz_hour      <= 2'd0;
      alarm_u_min  <= 4'd0;
      alarm_z_min  <= 3'd0;
      alarm_u_hour <= 4'd0;
      alarm_z_hour <= 2'd0;
    end else begin
      clk_load <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mode_p) begin
            state_reg    <= HOUR;
            target_alarm <= SW_alarm;
            if (SW_alarm) begin
              wu_min  <= alarm_u_min;
              wz_min  <= alarm_z_min;
              wu_hour <= alarm_u_hour;
              wz_hour <= alarm_z_hour;
            end else begin
              wu_min  <= clk_u_min_in;
              wz_min  <= clk_z_min_in;
              wu_hour <= clk_u_hour_in;
              wz_hour <= clk_z_hour_in;
            end
          end
        end
        HOUR: begin
          // Mode wins over a coincident inc press.
          if (mode_p) begin
            state_reg <= MIN;
          end else if (inc_p) begin
            if (wz_hour == 2'd2 && wu_hour == 4'd3) begin
              wz_hour <= 2'd0;
              wu_hour <= 4'd0;
            end else if (wu_hour == 4'd9) begin
              wu_hour <= 4'd0;
              wz_hour <= wz_hour + 2'd1;
            end else begin
              wu_hour <= wu_hour + 4'd1;
            end
          end
        end
        MIN: begin
          if (mode_p) begin
            state_reg <= IDLE;
            if (target_alarm) begin
              alarm_u_min  <= wu_min;
              alarm_z_min  <= wz_min;
              alarm_u_hour <= wu_hour;
              alarm_z_hour <= wz_hour;
            end else begin
              clk_load <= 1'b1;
            end
          end else if (inc_p) begin
            if (wu_min == 4'd9) begin
              wu_min <= 4'd0;
              wz_min <= (wz_min == 3'd5) ? 3'd0 : wz_min + 3'd1;
            end else begin
              wu_min <= wu_min + 4'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign set_state  = state_reg;
  assign set_u_min  = wu_min;
  assign set_z_min  = wz_min;
  assign set_u_hour = wu_hour;
  assign set_z_hour = wz_hour;

endmodule
